uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmitter among N_REQ requesters.
- Accepts one byte per requester through a valid/ready handshake and latches the per-frame parity configuration.
- Launches the transmitter with a one-cycle data-valid pulse.
- Tracks the transmitter's busy signal through the frame and enforces an optional idle gap between frames.
- Sits between the system-side producers and the UART TX datapath.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_scheduler_if.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 132 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the TX scheduler and friends
package uart_pkg;

  // Scheduler frame lifecycle: grant, launch pulse, wait for busy, frame, idle gap
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

  // Line levels of the framing bits
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity type encodings carried on req_parity_type / tx_parity_type
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transmitter handshake bundle for the TX scheduler
interface uart_tx_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);

  // Requester side
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_parity_en;
  logic [N_REQ-1:0]       req_parity_type;
  logic [N_REQ-1:0]       req_ready;

  // Transmitter side
  logic                   tx_busy;
  logic                   tx_data_valid;
  logic [WIDTH-1:0]       tx_p_data;
  logic                   tx_parity_en;
  logic                   tx_parity_type;

  // Scheduler view: accepts requests, drives the transmitter
  modport master (
    input  req_valid, req_data, req_parity_en, req_parity_type, tx_busy,
    output req_ready, tx_data_valid, tx_p_data, tx_parity_en, tx_parity_type
  );

  // Environment view: producers plus the UART TX datapath
  modport slave (
    output req_valid, req_data, req_parity_en, req_parity_type, tx_busy,
    input  req_ready, tx_data_valid, tx_p_data, tx_parity_en, tx_parity_type
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching from ptr+1 with wrap-around
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // First requesting index after the last winner gets the grant; last winner is checked last
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter among N_REQ requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int N_REQ         = 4,
  parameter int GAP_CYCLES    = 0,
  parameter int START_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_scheduler_if.master      bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     start_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = 16;

  sched_state_t     state;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    cnt;

  logic             tx_dv_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_pen_q;
  logic             tx_pty_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             accept;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // A grant only happens in IDLE with the transmitter quiet; reset masks the decode
  assign accept        = (state == IDLE) && arb_any && !bus.tx_busy && !rst;
  assign bus.req_ready = accept ? arb_gnt : '0;

  assign bus.tx_data_valid  = tx_dv_q;
  assign bus.tx_p_data      = tx_data_q;
  assign bus.tx_parity_en   = tx_pen_q;
  assign bus.tx_parity_type = tx_pty_q;

  // Frame scheduler: latch on accept, pulse launch, supervise busy, then enforce the idle gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IW'(N_REQ - 1);
      cnt       <= '0;
      grant_id  <= '0;
      active    <= 1'b0;
      start_err <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_data_q <= '0;
      tx_pen_q  <= 1'b0;
      tx_pty_q  <= 1'b0;
    end else begin
      tx_dv_q   <= 1'b0;
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data_q <= bus.req_data[arb_idx*WIDTH +: WIDTH];
            tx_pen_q  <= bus.req_parity_en[arb_idx];
            tx_pty_q  <= bus.req_parity_type[arb_idx];
            grant_id  <= arb_idx;
            rr_ptr    <= arb_idx;
            active    <= 1'b1;
            tx_dv_q   <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          // cnt tracks cycles since the launch pulse
          cnt   <= CW'(1);
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
            // Transmitter never took the frame: flag it and drop the frame
            start_err <= 1'b1;
            active    <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            cnt <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              active <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        GAP: begin
          if (cnt >= CW'(GAP_CYCLES - 1)) begin
            cnt    <= '0;
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          active <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed scoreboard bench for the UART TX round-robin scheduler
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int WIDTH    = 8;
  localparam int N_REQ    = 4;
  localparam int GAP      = 4;
  localparam int TMO      = 15;
  localparam int BUSY_LEN = 11;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       pen;
    logic       pty;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       par_en;
  logic [N_REQ-1:0]       par_ty;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [1:0]             grant_id;
  logic                   active;
  logic                   start_err;
  logic                   never_busy;
  int                     busy_cnt;

  uart_tx_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  assign bus.req_valid       = req_valid;
  assign bus.req_data        = req_data;
  assign bus.req_parity_en   = par_en;
  assign bus.req_parity_type = par_ty;
  assign bus.tx_busy         = (busy_cnt != 0);

  uart_tx_scheduler #(
    .WIDTH         (WIDTH),
    .N_REQ         (N_REQ),
    .GAP_CYCLES    (GAP),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .active    (active),
    .start_err (start_err)
  );

  // Transmitter model: busy for BUSY_LEN cycles starting the cycle after the launch pulse
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (bus.tx_data_valid && !never_busy) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ready_cyc = -10;
  int   launch_cyc = -100;
  int   fall_cyc = -1;
  int   upd_id = -1;
  int   drop_id = -1;
  int   launches = 0;
  int   timeouts = 0;
  bit   prev_busy = 1'b0;
  bit   have_cur = 1'b0;
  int   served[N_REQ];
  int   left[N_REQ];
  int   planned[N_REQ];
  exp_t sb[$];
  exp_t cur;

  function automatic logic [7:0] data_of(input int i, input int k);
    logic [7:0] base;
    case (i)
      0: base = 8'hA5;
      1: base = 8'h3C;
      2: base = 8'h5A;
      default: base = 8'hC3;
    endcase
    return base + 8'(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = data_of(id, planned[id]);
    e.pen  = par_en[id];
    e.pty  = par_ty[id];
    sb.push_back(e);
    planned[id]++;
  endtask

  task automatic drive_req(input int id, input int n);
    left[id]      = n;
    req_valid[id] = (n > 0);
    req_data[id*WIDTH +: WIDTH] = data_of(id, served[id]);
  endtask

  // One cycle: apply requester reactions at the negedge, then sample and check outputs
  task automatic step();
    logic             busy_now;
    logic [N_REQ-1:0] rdy;
    @(negedge clk);
    cyc++;
    busy_now = bus.tx_busy;
    if (upd_id >= 0) begin
      served[upd_id]++;
      left[upd_id]--;
      if (left[upd_id] <= 0) req_valid[upd_id] = 1'b0;
      req_data[upd_id*WIDTH +: WIDTH] = data_of(upd_id, served[upd_id]);
      upd_id = -1;
    end
    if (prev_busy && !busy_now) begin
      fall_cyc = cyc;
      if (drop_id >= 0) req_valid[drop_id] = 1'b0;
    end
    prev_busy = busy_now;
    #1;
    rdy = bus.req_ready;
    if (fall_cyc >= 0) begin
      if (cyc - fall_cyc <= GAP) begin
        check("gap_quiet", 32'(rdy), 0);
        check("gap_active", 32'(active), 1);
      end else begin
        if (|req_valid) check("gap_grant", 32'(|rdy), 1);
        fall_cyc = -1;
      end
    end
    if (rdy != '0) begin
      check("ready_onehot", $countones(rdy), 1);
      check("ready_needs_valid", 32'(rdy & ~req_valid), 0);
      check("ready_not_busy", 32'(busy_now), 0);
      for (int i = 0; i < N_REQ; i++) if (rdy[i]) upd_id = i;
      ready_cyc = cyc;
    end
    if (bus.tx_data_valid) begin
      check("launch_latency", cyc - ready_cyc, 1);
      check("launch_not_busy", 32'(busy_now), 0);
      check("launch_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        have_cur = 1'b1;
        check("launch_grant_id", 32'(grant_id), 32'(cur.id));
        check("launch_data", 32'(bus.tx_p_data), 32'(cur.data));
        check("launch_parity", 32'({bus.tx_parity_en, bus.tx_parity_type}), 32'({cur.pen, cur.pty}));
      end
      launch_cyc = cyc;
      launches++;
    end else if (busy_now && have_cur) begin
      check("frame_hold", 32'({bus.tx_p_data, bus.tx_parity_en, bus.tx_parity_type, grant_id}),
            32'({cur.data, cur.pen, cur.pty, cur.id}));
    end
    if (start_err) begin
      check("start_err_delay", cyc - launch_cyc, TMO);
      check("start_err_idle", 32'({active, dut.state == IDLE}), 32'b01);
      timeouts++;
    end
  endtask

  task automatic run(input int n, input int budget);
    int base_l;
    int t0;
    base_l = launches;
    t0 = cyc;
    while (launches < base_l + n && cyc - t0 < budget) step();
    check("run_launch_count", launches - base_l, n);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_dv"}, 32'(bus.tx_data_valid), 0);
    check({tag, "_data"}, 32'(bus.tx_p_data), 0);
    check({tag, "_par"}, 32'({bus.tx_parity_en, bus.tx_parity_type}), 0);
    check({tag, "_grant"}, 32'(grant_id), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_start_err"}, 32'(start_err), 0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    int t0;
    int s2;
    never_busy = 1'b0;
    par_en     = 4'b0101;
    par_ty     = {PAR_EVEN, PAR_ODD, PAR_EVEN, PAR_EVEN};
    req_valid  = '1;
    for (int i = 0; i < N_REQ; i++) begin
      served[i]  = 0;
      left[i]    = 0;
      planned[i] = 0;
      req_data[i*WIDTH +: WIDTH] = data_of(i, 0);
    end

    // Reset with every requester pending: all outputs must stay low
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_cleared("reset");

    // Release: requester 0 first, then full round 1, 2, 3
    for (int i = 0; i < N_REQ; i++) begin
      left[i] = 1;
      push_exp(i);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run(4, 300);

    // Requesters 0, 1, 3 continuous with parity on: order 0,1,3,0,1,3
    par_en = 4'b1111;
    par_ty = {PAR_ODD, PAR_EVEN, PAR_ODD, PAR_EVEN};
    drive_req(0, 2);
    drive_req(1, 2);
    drive_req(3, 2);
    for (int k = 0; k < 2; k++) begin
      push_exp(0);
      push_exp(1);
      push_exp(3);
    end
    run(6, 500);

    // Single requester back-to-back: gap of exactly GAP cycles checked in step()
    par_en[1] = 1'b0;
    drive_req(1, 2);
    push_exp(1);
    push_exp(1);
    run(2, 200);

    // Transmitter never goes busy: start_err after TMO cycles, frame dropped
    never_busy = 1'b1;
    drive_req(2, 1);
    push_exp(2);
    run(1, 200);
    t0 = cyc;
    while (timeouts < 1 && cyc - t0 < 40) step();
    check("timeout_seen", timeouts, 1);
    never_busy = 1'b0;
    drive_req(3, 1);
    push_exp(3);
    run(1, 200);

    // Requester 2 withdraws during the gap where it would win next: grant passes to 3
    drive_req(1, 1);
    push_exp(1);
    run(1, 200);
    s2 = served[2];
    drive_req(2, 1);
    drive_req(3, 1);
    drop_id = 2;
    push_exp(3);
    run(1, 200);
    drop_id = -1;
    check("withdrawn_not_served", served[2], s2);
    left[2] = 0;
    req_valid[2] = 1'b0;

    // Reset mid-frame in WAIT_DONE: everything clears, pointer restarts at requester 0
    drive_req(0, 1);
    push_exp(0);
    run(1, 200);
    t0 = cyc;
    while (!bus.tx_busy && cyc - t0 < 10) step();
    check("busy_rose_before_reset", 32'(bus.tx_busy), 1);
    step();
    step();
    check("in_wait_done", 32'(dut.state), 32'(WAIT_DONE));
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_cleared("midframe_reset");
    have_cur  = 1'b0;
    fall_cyc  = -1;
    prev_busy = 1'b0;
    upd_id    = -1;
    drive_req(0, 1);
    drive_req(1, 1);
    push_exp(0);
    push_exp(1);
    @(posedge clk);
    #1 rst = 1'b0;
    run(2, 300);

    check("scoreboard_drained", sb.size(), 0);
    check("timeouts_total", timeouts, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
